// File: rtl/tlc_monitor.sv
// tlc_monitor: safety/conflict monitor on the nine lamp outputs of the traffic light controller.
// Optional build macro FAULT_CLR_EN adds a fault_clr input that returns FAULT to MONITOR.
module tlc_monitor #(
  parameter int MIN_YEL   = 3,
  parameter int MAX_STUCK = 256,
  parameter int FLASH_DIV = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             R0G,
  input  logic             R0Y,
  input  logic             R0R,
  input  logic             R1G,
  input  logic             R1Y,
  input  logic             R1R,
  input  logic             CG,
  input  logic             CY,
  input  logic             CR,
`ifdef FAULT_CLR_EN
  input  logic             fault_clr,
`endif
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic             flash,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int YC_W  = $clog2(MIN_YEL + 1);
  localparam int ST_W  = $clog2(MAX_STUCK + 1);
  localparam int DIV_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

  localparam logic [2:0] LAMP_G = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b001;

  typedef enum logic {MONITOR = 1'b0, FAULT = 1'b1} state_t;
  typedef enum logic [2:0] {
    FC_NONE      = 3'd0,
    FC_CONFLICT  = 3'd1,
    FC_LAMP      = 3'd2,
    FC_SEQ       = 3'd3,
    FC_YEL_SHORT = 3'd4,
    FC_STUCK     = 3'd5
  } fcode_t;

  state_t               r_state, w_state_nxt;
  logic [2:0][2:0]      w_cur, r_prev;       // index 0 = R0, 1 = R1, 2 = C; bits {G,Y,R}
  logic [2:0][YC_W-1:0] r_ycnt;
  logic [ST_W-1:0]      r_stuck, w_stuck_nxt;
  logic [DIV_W-1:0]     r_div;
  logic [2:0]           r_code;
  logic                 r_flash;
  logic [CNT_W-1:0]     r_cnt;
  fcode_t               w_code;
  logic [1:0]           w_nonred;
  logic                 w_conflict, w_lamp, w_seq, w_yshort, w_stuck, w_same;

  function automatic logic is_onehot(input logic [2:0] v);
    return (v == LAMP_G) || (v == LAMP_Y) || (v == LAMP_R);
  endfunction

  assign w_cur       = {{CG, CY, CR}, {R1G, R1Y, R1R}, {R0G, R0Y, R0R}};
  assign w_same      = (w_cur == r_prev);
  assign w_stuck_nxt = w_same ? r_stuck + 1'b1 : '0;
  assign w_stuck     = w_same && (r_stuck == ST_W'(MAX_STUCK - 1));
  assign w_conflict  = (w_nonred > 2'd1);

  // Exact-value compares make the SEQ/YEL_SHORT checks ignore non-one-hot samples.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    w_nonred = '0;
    w_lamp   = 1'b0;
    w_seq    = 1'b0;
    w_yshort = 1'b0;
    for (int h = 0; h < 3; h++) begin
      w_nonred = w_nonred + {1'b0, w_cur[h][2] | w_cur[h][1]};
      if (!is_onehot(w_cur[h])) w_lamp = 1'b1;
      if ((r_prev[h] == LAMP_G && w_cur[h] == LAMP_R) ||
          (r_prev[h] == LAMP_Y && w_cur[h] == LAMP_G) ||
          (r_prev[h] == LAMP_R && w_cur[h] == LAMP_Y)) w_seq = 1'b1;
      if (r_prev[h] == LAMP_Y && w_cur[h] == LAMP_R && r_ycnt[h] < YC_W'(MIN_YEL))
        w_yshort = 1'b1;
    end
  end

  always_comb begin
    if (w_conflict)    w_code = FC_CONFLICT;
    else if (w_lamp)   w_code = FC_LAMP;
    else if (w_seq)    w_code = FC_SEQ;
    else if (w_yshort) w_code = FC_YEL_SHORT;
    else if (w_stuck)  w_code = FC_STUCK;
    else               w_code = FC_NONE;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      MONITOR: if (w_code != FC_NONE) w_state_nxt = FAULT;
      FAULT: begin
`ifdef FAULT_CLR_EN
        if (fault_clr) w_state_nxt = MONITOR;
`endif
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= MONITOR;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev  <= {LAMP_R, LAMP_R, LAMP_R};
      r_ycnt  <= '0;
      r_stuck <= '0;
      r_div   <= '0;
      r_code  <= '0;
      r_flash <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == MONITOR) begin
      r_prev  <= w_cur;
      r_stuck <= w_stuck_nxt;
      r_code  <= w_code;  // zero unless a violation is latched on this edge
      for (int h = 0; h < 3; h++) begin
        if (w_cur[h] != LAMP_Y)                  r_ycnt[h] <= '0;
        else if (r_ycnt[h] != YC_W'(MIN_YEL))    r_ycnt[h] <= r_ycnt[h] + 1'b1;
      end
      if (r_prev[0] == LAMP_R && w_cur[0] == LAMP_G) r_cnt <= r_cnt + 1'b1;
    end else begin
`ifdef FAULT_CLR_EN
      if (fault_clr) begin
        r_prev  <= w_cur;
        r_ycnt  <= '0;
        r_stuck <= '0;
        r_div   <= '0;
        r_code  <= '0;
        r_flash <= 1'b0;
      end else begin
`else
      begin
`endif
        if (r_div == DIV_W'(FLASH_DIV - 1)) begin
          r_div   <= '0;
          r_flash <= ~r_flash;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end
    end
  end

  assign fault      = (r_state == FAULT);
  assign fault_code = r_code;
  assign flash      = r_flash;
  assign cycle_cnt  = r_cnt;

endmodule

// File: tb/tb_tlc_monitor.sv
// Self-checking bench for tlc_monitor: a reference model pushes expected outputs into a
// scoreboard each time a lamp sample is driven; they are popped and compared after the edge.
module tb_tlc_monitor;

  localparam logic [2:0] G = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b001;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  lamp [3];
  logic        R0G, R0Y, R0R, R1G, R1Y, R1R, CG, CY, CR;
`ifdef FAULT_CLR_EN
  logic        fault_clr = 1'b0;
`endif
  logic        fault;
  logic [2:0]  fault_code;
  logic        flash;
  logic [15:0] cycle_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        fault;
    logic [2:0]  code;
    logic        flash;
    logic [15:0] cnt;
  } exp_t;
  exp_t  sb[$];
  string sb_tag[$];

  // reference model state
  bit          m_fault;
  logic [2:0]  m_code;
  bit          m_flash;
  int          m_div;
  logic [15:0] m_cnt;
  logic [2:0]  m_prev [3];
  int          m_ycnt [3];
  int          m_stuck;

  always #5 clk = ~clk;

  assign {R0G, R0Y, R0R} = lamp[0];
  assign {R1G, R1Y, R1R} = lamp[1];
  assign {CG, CY, CR}    = lamp[2];

  tlc_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .R0G        (R0G),
    .R0Y        (R0Y),
    .R0R        (R0R),
    .R1G        (R1G),
    .R1Y        (R1Y),
    .R1R        (R1R),
    .CG         (CG),
    .CY         (CY),
    .CR         (CR),
`ifdef FAULT_CLR_EN
    .fault_clr  (fault_clr),
`endif
    .fault      (fault),
    .fault_code (fault_code),
    .flash      (flash),
    .cycle_cnt  (cycle_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit onehot(input logic [2:0] v);
    return v == G || v == Y || v == R;
  endfunction

  // Allowed successor of each lamp state (staying put is always allowed).
  function automatic bit legal_next(input logic [2:0] p, input logic [2:0] c);
    case (p)
      G:       return c == G || c == Y;
      Y:       return c == Y || c == R;
      R:       return c == R || c == G;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_fault = 0; m_code = 0; m_flash = 0; m_div = 0; m_cnt = 0; m_stuck = 0;
    for (int h = 0; h < 3; h++) begin
      m_prev[h] = R;
      m_ycnt[h] = 0;
    end
  endtask

  task automatic model_step(input bit clr);
    int nonred, st;
    bit bad_lamp, bad_seq, short_y, same;
    logic [2:0] code;
    if (!m_fault) begin
      nonred = 0; bad_lamp = 0; bad_seq = 0; short_y = 0; same = 1;
      for (int h = 0; h < 3; h++) begin
        if (lamp[h][2] || lamp[h][1]) nonred++;
        if (!onehot(lamp[h])) bad_lamp = 1;
        if (onehot(m_prev[h]) && onehot(lamp[h]) && !legal_next(m_prev[h], lamp[h])) bad_seq = 1;
        if (m_prev[h] == Y && lamp[h] == R && m_ycnt[h] < 3) short_y = 1;
        if (lamp[h] != m_prev[h]) same = 0;
      end
      st = same ? m_stuck + 1 : 0;
      if (nonred > 1)      code = 3'd1;
      else if (bad_lamp)   code = 3'd2;
      else if (bad_seq)    code = 3'd3;
      else if (short_y)    code = 3'd4;
      else if (st >= 256)  code = 3'd5;
      else                 code = 3'd0;
      if (m_prev[0] == R && lamp[0] == G) m_cnt = m_cnt + 16'd1;
      for (int h = 0; h < 3; h++) begin
        m_ycnt[h] = (lamp[h] == Y) ? ((m_ycnt[h] < 3) ? m_ycnt[h] + 1 : 3) : 0;
        m_prev[h] = lamp[h];
      end
      m_stuck = st;
      if (code != 0) begin
        m_fault = 1;
        m_code  = code;
      end
    end else if (clr) begin
      m_fault = 0; m_code = 0; m_flash = 0; m_div = 0; m_stuck = 0;
      for (int h = 0; h < 3; h++) begin
        m_prev[h] = lamp[h];
        m_ycnt[h] = 0;
      end
    end else if (m_div == 3) begin
      m_div   = 0;
      m_flash = !m_flash;
    end else begin
      m_div++;
    end
  endtask

  // Drive one sample, push the model's expectation, compare once the DUT has clocked it.
  task automatic step(input string tag, input logic [2:0] a, input logic [2:0] b,
                      input logic [2:0] c, input bit clr = 1'b0);
    exp_t  e;
    string t;
    @(negedge clk);
    lamp[0] = a; lamp[1] = b; lamp[2] = c;
`ifdef FAULT_CLR_EN
    fault_clr = clr;
`endif
    model_step(clr);
    e.fault = m_fault; e.code = m_code; e.flash = m_flash; e.cnt = m_cnt;
    sb.push_back(e);
    sb_tag.push_back(tag);
    @(posedge clk);
    #1;
`ifdef FAULT_CLR_EN
    fault_clr = 1'b0;
`endif
    check({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      t = sb_tag.pop_front();
      check({t, "_fault"}, fault, e.fault);
      check({t, "_code"},  fault_code, e.code);
      check({t, "_flash"}, flash, e.flash);
      check({t, "_cnt"},   cycle_cnt, e.cnt);
    end
  endtask

  task automatic hold(input string tag, input logic [2:0] a, input logic [2:0] b,
                      input logic [2:0] c, input int n);
    for (int i = 0; i < n; i++) step(tag, a, b, c);
  endtask

  // Reset is raised between clock edges and the outputs are checked before any edge arrives.
  task automatic do_reset(input string tag);
    #1;
    reset = 1'b1;
    lamp[0] = R; lamp[1] = R; lamp[2] = R;
    #1;
    check({tag, "_rst_fault"}, fault, 0);
    check({tag, "_rst_code"},  fault_code, 0);
    check({tag, "_rst_flash"}, flash, 0);
    check({tag, "_rst_cnt"},   cycle_cnt, 0);
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    do_reset("init");

    // three full legal rounds
    for (int rep = 0; rep < 3; rep++) begin
      hold("leg_r0g", G, R, R, 5);
      hold("leg_r0y", Y, R, R, 3);
      hold("leg_r1g", R, G, R, 5);
      hold("leg_r1y", R, Y, R, 3);
      hold("leg_cg",  R, R, G, 5);
      hold("leg_cy",  R, R, Y, 3);
    end
    step("leg_allr", R, R, R);
    check("legal_cnt", cycle_cnt, 3);
    check("legal_fault", fault, 0);

    // stuck boundary: 255 unchanged then a change is fine, 256 unchanged faults
    hold("stk_255", R, R, R, 255);
    step("stk_chg", G, R, R);
    check("stuck_255_fault", fault, 0);
    hold("stk_hold", G, R, R, 255);
    check("stuck_pre_fault", fault, 0);
    step("stk_256", G, R, R);
    check("stuck_code", fault_code, 5);
    hold("stk_flash", G, R, R, 4);
    check("stuck_flash_hi", flash, 1);
    do_reset("stuck_async");

    // conflict, flash cadence and frozen cycle counter
    step("cf_r0g", G, R, R);
    step("cf_both", G, G, R);
    check("conf_code", fault_code, 1);
    check("conf_fault", fault, 1);
    step("cf_f1", R, R, R);
    step("cf_f2", G, R, R);
    step("cf_f3", R, R, R);
    check("conf_flash_lo", flash, 0);
    step("cf_f4", G, R, R);
    check("conf_flash_hi", flash, 1);
    hold("cf_f5", R, R, R, 4);
    check("conf_flash_lo2", flash, 0);
    check("conf_cnt_frozen", cycle_cnt, 1);
    do_reset("conf");

    // green straight to red
    step("seq_g", G, R, R);
    step("seq_r", R, R, R);
    check("seq_code", fault_code, 3);
    do_reset("seq");

    // yellow too short
    step("ys_g", G, R, R);
    hold("ys_y", Y, R, R, 2);
    step("ys_r", R, R, R);
    check("yshort_code", fault_code, 4);
    do_reset("ysh");

    // dark head
    step("lamp_dark", 3'b000, R, R);
    check("lamp_code", fault_code, 2);
    do_reset("lamp");

    // conflict outranks lamp
    step("pri_r1g", R, G, R);
    step("pri_both", 3'b101, G, R);
    check("prio_code", fault_code, 1);
    do_reset("prio");

`ifdef FAULT_CLR_EN
    step("clr_r0g", G, R, R);
    step("clr_conf", G, G, R);
    check("clr_pre_code", fault_code, 1);
    step("clr_pulse", R, R, R, 1'b1);
    check("clr_fault", fault, 0);
    check("clr_code", fault_code, 0);
    check("clr_cnt_kept", cycle_cnt, 1);
    hold("clr_g", G, R, R, 5);
    hold("clr_y", Y, R, R, 3);
    step("clr_r", R, R, R);
    check("clr_after_fault", fault, 0);
    check("clr_after_cnt", cycle_cnt, 2);
    do_reset("clr");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
